// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed BCD converter
// One input bit per clock; bcd_out/ovf update only on the edge entering DONE.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WIDTH-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                ovf_q;
  logic [CW-1:0]       cnt;

  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_shf;
  logic [WIDTH-1:0]    bin_shf;
  logic                ovf_step;

  // A corrected top digit of 8 or more carries out of the digit field on the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    ovf_step = ovf_q | bcd_adj[4*DIGITS-1];
    bcd_shf  = {bcd_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
    bin_shf  = bin_q << 1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_q <= bin_in;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt   <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          bin_q <= bin_shf;
          bcd_q <= bcd_shf;
          ovf_q <= ovf_step;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_out <= bcd_shf;
            ovf     <= ovf_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
// Three instances (5/2, 8/3, 8/2) checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic [7:0]  bin_bus = 8'd0;

  logic        busy_a, done_a, ovf_a;
  logic [7:0]  bcd_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_b;
  logic        busy_c, done_c, ovf_c;
  logic [7:0]  bcd_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel = 0;
  int wd[3] = '{5, 8, 8};
  int dg[3] = '{2, 3, 2};
  logic [31:0] last[3] = '{32'd0, 32'd0, 32'd0};

  logic        sel_busy, sel_done, sel_ovf;
  logic [11:0] sel_bcd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.WIDTH(5), .DIGITS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin_in(bin_bus[4:0]),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin_in(bin_bus),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin_in(bin_bus),
    .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .ovf(ovf_c));

  always_comb begin
    sel_busy = busy_a; sel_done = done_a; sel_ovf = ovf_a; sel_bcd = {4'd0, bcd_a};
    case (sel)
      1: begin sel_busy = busy_b; sel_done = done_b; sel_ovf = ovf_b; sel_bcd = bcd_b; end
      2: begin sel_busy = busy_c; sel_done = done_c; sel_ovf = ovf_c; sel_bcd = {4'd0, bcd_c}; end
      default: ;
    endcase
  end

  function automatic logic [31:0] ref_bcd(input int v, input int d);
    logic [31:0] r;
    int x;
    r = 0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r = r | (32'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_ovf(input int v, input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return (v >= p) ? 32'd1 : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a conversion on instance inst; optionally re-pulses start with bin 7 mid-shift.
  task automatic convert(input int inst, input int v, input int inject_at,
                         output int lat, output int dcyc);
    logic [31:0] exp_bcd;
    sel = inst;
    bin_bus = v[7:0];
    start_v = 3'b000;
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v = 3'b000;
    lat = -1;
    dcyc = -1;
    for (int n = 1; n <= 20; n++) begin
      if (sel_done) begin
        lat = n;
        dcyc = cyc;
        break;
      end
      chk("busy_during_shift", {31'd0, sel_busy}, 32'd1);
      chk("bcd_held_during_shift", {20'd0, sel_bcd}, last[inst]);
      if (n == inject_at) begin
        start_v[inst] = 1'b1;
        bin_bus = 8'd7;
      end else begin
        start_v = 3'b000;
      end
      @(negedge clk);
    end
    exp_bcd = ref_bcd(v, dg[inst]);
    chk("latency", lat, wd[inst] + 1);
    chk("bcd_out", {20'd0, sel_bcd}, exp_bcd);
    chk("ovf", {31'd0, sel_ovf}, ref_ovf(v, dg[inst]));
    chk("busy_low_in_done", {31'd0, sel_busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, sel_done}, 32'd0);
    chk("bcd_held_after_done", {20'd0, sel_bcd}, exp_bcd);
    last[inst] = exp_bcd;
  endtask

  initial begin
    int lat, d0, d1, d2;
    bit seen_done;

    repeat (2) @(negedge clk);
    chk("rst_busy", {29'd0, busy_a, busy_b, busy_c}, 32'd0);
    chk("rst_done", {29'd0, done_a, done_b, done_c}, 32'd0);
    chk("rst_ovf", {29'd0, ovf_a, ovf_b, ovf_c}, 32'd0);
    chk("rst_bcd", {bcd_a, bcd_b, bcd_c}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(0, 31, 0, lat, d0);

    convert(0, 0, 0, lat, d0);
    convert(0, 9, 0, lat, d1);
    convert(0, 10, 0, lat, d2);
    chk("done_spacing_1", d1 - d0, 32'd7);
    chk("done_spacing_2", d2 - d1, 32'd7);

    convert(0, 12, 2, lat, d0);
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_a) seen_done = 1'b1;
    end
    chk("ignored_start_no_done", {31'd0, seen_done}, 32'd0);

    convert(1, 255, 0, lat, d0);
    convert(1, 128, 0, lat, d0);
    convert(2, 200, 0, lat, d0);
    convert(2, 99, 0, lat, d0);
    convert(2, 100, 0, lat, d0);
    convert(1, 0, 0, lat, d0);

    for (int k = 0; k < 12; k++) begin
      convert(0, int'($urandom_range(0, 31)), 0, lat, d0);
      convert(1, int'($urandom_range(0, 255)), 0, lat, d0);
      convert(2, int'($urandom_range(0, 255)), 0, lat, d0);
    end

    convert(0, 12, 0, lat, d0);
    sel = 0;
    bin_bus = 8'd25;
    start_v = 3'b001;
    @(negedge clk);
    start_v = 3'b000;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("async_rst_done", {31'd0, done_a}, 32'd0);
    chk("async_rst_bcd", {24'd0, bcd_a}, 32'd0);
    chk("async_rst_ovf", {31'd0, ovf_a}, 32'd0);
    chk("async_rst_bcd_c", {24'd0, bcd_c}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last[0] = 0; last[1] = 0; last[2] = 0;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_a) seen_done = 1'b1;
    end
    chk("no_done_after_abort", {31'd0, seen_done}, 32'd0);
    convert(0, 25, 0, lat, d0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
